// File: rtl/pico_sequencer.sv
// picoMips instruction-phase controller: PC, FETCH/DECODE/EXEC/WB FSM with HEI wait, SW8 debounce.
// Optional: define PICO_SINGLE_STEP_EN to add the `step` input that gates FETCH one instruction at a time.
module pico_sequencer #(
  parameter int PC_WIDTH   = 5,
  parameter int PROG_LAST  = 23,
  parameter int DEB_CYCLES = 4,
  parameter int DEB_WIDTH  = 3
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic [2:0]          func,
  input  logic                hei_arg,
  input  logic                sw_go,
`ifdef PICO_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          phase,
  output logic                fetch_en,
  output logic                acc_we,
  output logic                reg_we,
  output logic                waiting,
  output logic                go_db
);

  localparam logic [2:0] OP_HEI = 3'b110;
  localparam logic [2:0] OP_ATR = 3'b111;

  localparam logic [DEB_WIDTH-1:0] DEB_LAST     = DEB_WIDTH'(DEB_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0]  PROG_LAST_PC = PC_WIDTH'(PROG_LAST);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_WAIT
  } state_t;

  state_t               state, state_next;
  logic                 go_s1, go_s2;
  logic [DEB_WIDTH-1:0] deb_cnt;
  logic                 fetch_go;
  logic [PC_WIDTH-1:0]  pc_next;

  // SW8: 2-flop synchroniser, then go_db toggles after DEB_CYCLES stable disagreeing cycles
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      go_s1   <= 1'b0;
      go_s2   <= 1'b0;
      go_db   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      go_s1 <= sw_go;
      go_s2 <= go_s1;
      if (go_s2 != go_db) begin
        if (deb_cnt == DEB_LAST) begin
          go_db   <= ~go_db;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

`ifdef PICO_SINGLE_STEP_EN
  logic step_s1, step_s2, step_d;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      step_s1 <= step;
      step_s2 <= step_s1;
      step_d  <= step_s2;
    end
  end

  // One-cycle rise pulse; only consumed in FETCH, so edges seen elsewhere are lost
  assign fetch_go = step_s2 & ~step_d;
`else
  assign fetch_go = 1'b1;
`endif

  assign pc_next = (pc >= PROG_LAST_PC) ? '0 : pc + 1'b1;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_FETCH;
      pc    <= '0;
    end else begin
      state <= state_next;
      if (state == S_WB) pc <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    phase      = 2'd0;
    fetch_en   = 1'b0;
    acc_we     = 1'b0;
    reg_we     = 1'b0;
    waiting    = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_en = 1'b1;
        if (fetch_go) state_next = S_DECODE;
      end
      S_DECODE: begin
        phase      = 2'd1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        phase = 2'd2;
        if (func == OP_HEI && go_db == hei_arg) state_next = S_WAIT;
        else                                     state_next = S_WB;
      end
      S_WAIT: begin
        phase   = 2'd2;
        waiting = 1'b1;
        if (go_db != hei_arg) state_next = S_WB;
      end
      S_WB: begin
        phase      = 2'd3;
        acc_we     = (func != OP_HEI) && (func != OP_ATR);
        reg_we     = (func == OP_ATR);
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

endmodule
